// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
//   Three-channel PWM generator for an RGB LED. A shared period counter runs
//   from 0 to PWM_INTERVAL-1 and wraps. Each channel holds a shadow copy of
//   its duty. All three shadows are refreshed together on the last cycle of a
//   period, so a duty change never tears a period in half. A pin is "on" while
//   the counter is below that channel's shadow duty. The pins are registered,
//   so they lag the counter by one cycle.
//
// Parameters
//   PWM_INTERVAL : period length in clk cycles
//   ACTIVE_LOW   : 1 -> pins are driven low for "on", 0 -> driven high for "on"
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   duty_r/g/b   : per-channel on-time in clk cycles per period
//   red/green/blue : LED pins
//   period_start : one-cycle pulse on the first pin cycle of each period
module rgb_pwm_driver #(
    parameter int PWM_INTERVAL = 1200,
    parameter bit ACTIVE_LOW   = 1'b1,
    localparam int W           = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] duty_r,
    input  logic [W-1:0] duty_g,
    input  logic [W-1:0] duty_b,
    output logic         red,
    output logic         green,
    output logic         blue,
    output logic         period_start
);

    localparam logic [W-1:0] LAST_CNT  = W'(PWM_INTERVAL - 1);
    localparam logic         OFF_LEVEL = ACTIVE_LOW;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] sh_r_q, sh_r_d;
    logic [W-1:0] sh_g_q, sh_g_d;
    logic [W-1:0] sh_b_q, sh_b_d;
    logic [2:0]   pin_q, pin_d;
    logic         period_start_q, period_start_d;
    logic         wrap;
    logic [2:0]   on;

    // Next-state logic. A shadow duty at or above PWM_INTERVAL needs no
    // explicit clamp: the counter never reaches it, so the channel simply
    // stays on for the whole period. XOR with the off level turns "on" into
    // the correct pin polarity.
    always_comb begin
        wrap           = (cnt_q == LAST_CNT);
        cnt_d          = wrap ? '0 : cnt_q + W'(1);
        sh_r_d         = wrap ? duty_r : sh_r_q;
        sh_g_d         = wrap ? duty_g : sh_g_q;
        sh_b_d         = wrap ? duty_b : sh_b_q;
        on[0]          = (cnt_q < sh_r_q);
        on[1]          = (cnt_q < sh_g_q);
        on[2]          = (cnt_q < sh_b_q);
        pin_d          = on ^ {3{OFF_LEVEL}};
        period_start_d = (cnt_q == '0);
    end

    // State registers. Reset forces the pins off immediately and throws away
    // any duty that was waiting to load, so the first period after reset is
    // dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            sh_r_q         <= '0;
            sh_g_q         <= '0;
            sh_b_q         <= '0;
            pin_q          <= {3{OFF_LEVEL}};
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            sh_r_q         <= sh_r_d;
            sh_g_q         <= sh_g_d;
            sh_b_q         <= sh_b_d;
            pin_q          <= pin_d;
            period_start_q <= period_start_d;
        end
    end

    assign red          = pin_q[0];
    assign green        = pin_q[1];
    assign blue         = pin_q[2];
    assign period_start = period_start_q;

endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning PWM period length in clk cycles (100 us at 12 MHz).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, meaning LED pins are driven low for "on" when 1 and high for "on" when 0.
REQ-003 SHALL define W = $clog2(PWM_INTERVAL), which is 11 at the default.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port duty_r, input, W bits: red on-time in clk cycles per period, driven by the fade stage.
REQ-007 SHALL have port duty_g, input, W bits: green on-time in clk cycles per period.
REQ-008 SHALL have port duty_b, input, W bits: blue on-time in clk cycles per period.
REQ-009 SHALL have port red, output, 1 bit: red LED pin.
REQ-010 SHALL have port green, output, 1 bit: green LED pin.
REQ-011 SHALL have port blue, output, 1 bit: blue LED pin.
REQ-012 SHALL have port period_start, output, 1 bit: one-cycle pulse marking the first pin cycle of each period.

Function
REQ-013 SHALL keep a period counter cnt (W bits) that increments by 1 every clk and wraps from PWM_INTERVAL-1 to 0.
REQ-014 SHALL keep one shadow duty register per channel (sh_r, sh_g, sh_b) and load all three from duty_r/g/b in the same cycle, only on the clk edge where cnt == PWM_INTERVAL-1.
REQ-015 SHALL ignore duty input changes at all other times; a mid-period change takes effect only from the next period.
REQ-016 SHALL compute a per-channel "on" value combinationally as (cnt < sh_x) and register it into the pin, so each pin lags cnt by exactly 1 cycle.
REQ-017 SHALL drive each pin as ~on when ACTIVE_LOW = 1 and as on when ACTIVE_LOW = 0.
REQ-018 SHALL produce exactly sh_x on-cycles per period, contiguous and beginning at the pin cycle after cnt == 0.
REQ-019 SHALL keep a channel off for the whole period when its duty is 0, with no glitch.
REQ-020 SHALL clamp duty >= PWM_INTERVAL (representable when PWM_INTERVAL is not a power of 2) to always-on for the whole period.
REQ-021 SHALL treat the channels independently; equal duties produce pin edges in the same cycle.
REQ-022 SHALL register period_start and assert it for one cycle, in the same cycle the pins first reflect cnt == 0.
REQ-023 SHALL ensure period_start never asserts twice within PWM_INTERVAL cycles.
REQ-024 SHALL use unsigned comparison throughout; cnt SHALL never take values >= PWM_INTERVAL.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously clear cnt to 0, clear sh_r/sh_g/sh_b to 0, clear period_start to 0, and drive all pins to the off level (1 when ACTIVE_LOW = 1).
REQ-026 SHALL, after rst_n deasserts, count from 0 on the first rising clk edge.
REQ-027 SHALL keep all pins off for the first full period after reset, because the shadows are 0, and apply the first duties from the second period onward.
REQ-028 SHALL, on reset asserted mid-period, force pins off immediately without waiting for clk, and discard any pending duty.

Verification (PWM_INTERVAL = 10, ACTIVE_LOW = 1 unless stated)
REQ-029 SHALL cover: reset, then duty_r/g/b = 3/0/10 held -> period 1 all pins 1; period 2 red low exactly 3 cycles starting the cycle period_start = 1, green 1 for all 10 cycles, blue 0 for all 10 cycles.
REQ-030 SHALL cover: duty_r changed 3 -> 7 at cnt = 4 -> the current period still shows 3 low cycles; the next period shows 7 low cycles.
REQ-031 SHALL cover: duty_g = 15 with PWM_INTERVAL = 12 -> green low for all 12 cycles of every period.
REQ-032 SHALL cover: 100 cycles with no reset -> period_start pulses exactly every 10 cycles, each pulse 1 cycle wide.
REQ-033 SHALL cover: rst_n pulsed low between clk edges while red is low -> red goes to 1 before the next edge, period_start = 0, and the following period is all off.
REQ-034 SHALL cover: ACTIVE_LOW = 0 with duty_b = 4 -> blue high for exactly 4 cycles per period and 0 during reset.
